// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its bit-timing helper.
// State encoding, frame length and counter-width sizing live here.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int FRAME_BITS    = DEFAULT_WIDTH + 2;

  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction

  // Counters never shrink below one bit, even for a range of a single value.
  function automatic int cnt_width(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_tick.sv
// Per-bit cycle counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle.
// Kept separate so the receive side can reuse the same bit timing.
module bit_tick
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, stop bit.
// The serial line is a flop so downstream stages never see load/din glitches.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             tick;
  logic             in_idle;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  assign in_idle  = (state_q == IDLE);
  assign next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
  assign last_bit = (bit_cnt_q == LAST_BIT);

  bit_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_tick (
    .clk  (clk),
    .reset(reset),
    .clear(in_idle),
    .en   (!in_idle),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && last_bit) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next line level is computed one cycle ahead so it lands on the bit boundary.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sout_d    = sout_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        sout_d    = IDLE_LEVEL;
        if (load) begin
          shift_d = din;
          sout_d  = ~IDLE_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          sout_d    = next_bit;
          shift_d   = shifted;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (last_bit) begin
            sout_d = IDLE_LEVEL;
          end else begin
            sout_d    = next_bit;
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP:    sout_d = IDLE_LEVEL;
      default: sout_d = IDLE_LEVEL;
    endcase
  end

  always_comb begin
    ready = in_idle;
    busy  = !in_idle;
    done  = (state_q == STOP) && tick;
    sout  = sout_q;
  end

endmodule
